lfsr_rng: RTL and testbench

Parametrised Fibonacci-LFSR random number generator with a request/valid handshake and a bounded-range output. Each draw advances the LFSR a configurable number of steps. The result is then mapped into `0..limit` by masked rejection sampling, with a deterministic fallback after a bounded number of retries. The block serves game logic that needs random positions or choices. It replaces the fixed 13-bit free-running generator.

---
 rtl/lfsr_rng.sv | 147 ++++++++++++++
 tb/tb_lfsr_rng.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng.sv
// Fibonacci-LFSR random number generator with a req/valid handshake.
// Results are bounded to 0..limit by masked rejection sampling with a deterministic fallback.
module lfsr_rng #(
  parameter int unsigned       WIDTH     = 13,
  parameter logic [WIDTH-1:0]  TAPS      = 13'h100D,
  parameter logic [WIDTH-1:0]  SEED      = 13'h000F,
  parameter int unsigned       STEPS     = 13,
  parameter int unsigned       MAX_RETRY = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  input  logic [WIDTH-1:0] limit,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] rnd
);

  localparam int SCW = $clog2(STEPS + 1);
  localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [SCW-1:0] LAST_STEP   = SCW'(STEPS - 1);
  localparam logic [RCW-1:0] RETRY_LIMIT = RCW'(MAX_RETRY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_CHECK
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [SCW-1:0]   step_q, step_d;
  logic [RCW-1:0]   retry_q, retry_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] rnd_q, rnd_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] mask_w;
  logic             fb_w;
  logic [WIDTH-1:0] lfsr_shift_w;
  logic [WIDTH-1:0] sample_w;
  logic [WIDTH-1:0] fallback_w;
  logic [WIDTH-1:0] seed_w;

  // Mask bit i is set when any limit bit at or above i is set: smallest 2^k-1 >= limit.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_mask
      assign mask_w[gi] = |limit[WIDTH-1:gi];
    end
  endgenerate

  assign fb_w         = ^(lfsr_q & TAPS);
  assign lfsr_shift_w = {lfsr_q[WIDTH-2:0], fb_w};
  assign sample_w     = lfsr_q & mask_q;
  // Only used when sample > limit, so limit+1 cannot wrap here.
  assign fallback_w   = sample_w - limit_q - WIDTH'(1);
  assign seed_w       = (seed_in == '0) ? SEED : seed_in;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    step_d  = step_q;
    retry_d = retry_q;
    limit_d = limit_q;
    mask_d  = mask_q;
    rnd_d   = rnd_q;
    valid_d = 1'b0;

    if (seed_load) begin
      lfsr_d  = seed_w;
      state_d = S_IDLE;
      step_d  = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            limit_d = limit;
            mask_d  = mask_w;
            step_d  = '0;
            retry_d = '0;
            state_d = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (enable) begin
            lfsr_d = lfsr_shift_w;
            step_d = step_q + 1'b1;
            if (step_q == LAST_STEP) begin
              state_d = S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (sample_w <= limit_q) begin
            rnd_d   = sample_w;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else if (retry_q == RETRY_LIMIT) begin
            rnd_d   = fallback_w;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            retry_d = retry_q + 1'b1;
            step_d  = '0;
            state_d = S_SHIFT;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      step_q  <= '0;
      retry_q <= '0;
      limit_q <= '0;
      mask_q  <= '0;
      rnd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      step_q  <= step_d;
      retry_q <= retry_d;
      limit_q <= limit_d;
      mask_q  <= mask_d;
      rnd_q   <= rnd_d;
      valid_q <= valid_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign valid = valid_q;
  assign rnd   = rnd_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// Bench for lfsr_rng: default, MAX_RETRY=0 and 8-bit maximal-period instances,
// checked against hand vectors and a draw-level reference model.
module tb_lfsr_rng;

  localparam int          STEPS  = 13;
  localparam logic [12:0] SEED13 = 13'h000F;
  localparam int          TAPS13 = 'h100D;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        en0, sl0, req0, busy0, valid0;
  logic [12:0] seed0, lim0, rnd0;
  logic        en1, sl1, req1, busy1, valid1;
  logic [12:0] seed1, lim1, rnd1;
  logic        en8, sl8, req8, busy8, valid8;
  logic [7:0]  seed8, lim8, rnd8;

  lfsr_rng u_dut0 (
    .clock(clock), .reset(reset), .enable(en0), .seed_load(sl0), .seed_in(seed0),
    .req(req0), .limit(lim0), .busy(busy0), .valid(valid0), .rnd(rnd0)
  );
  lfsr_rng #(.MAX_RETRY(0)) u_dut1 (
    .clock(clock), .reset(reset), .enable(en1), .seed_load(sl1), .seed_in(seed1),
    .req(req1), .limit(lim1), .busy(busy1), .valid(valid1), .rnd(rnd1)
  );
  lfsr_rng #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEPS(1), .MAX_RETRY(3)) u_dut8 (
    .clock(clock), .reset(reset), .enable(en8), .seed_load(sl8), .seed_in(seed8),
    .req(req8), .limit(lim8), .busy(busy8), .valid(valid8), .rnd(rnd8)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int m0, m1, m8;

  typedef struct packed {
    logic [1:0]  sel;
    logic [12:0] lim;
    logic [12:0] exp_rnd;
    logic [7:0]  exp_lat;
  } vec_t;
  vec_t vecs [16];

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic finish_now;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Draw-level model: whole attempts computed with plain integer arithmetic.
  function automatic int lfsr_next(input int v, input int w, input int taps);
    return ((v << 1) | ($countones(v & taps) & 1)) & ((1 << w) - 1);
  endfunction

  task automatic model_draw(inout int st, input int lim, input int w, input int taps,
                            input int steps, input int maxr, output int res, output int att);
    int m;
    int s;
    m = 0;
    while (m < lim) m = m * 2 + 1;
    att = 0;
    while (1) begin
      att++;
      for (int k = 0; k < steps; k++) st = lfsr_next(st, w, taps);
      s = st & m;
      if (s <= lim) begin
        res = s;
        break;
      end
      if (att - 1 == maxr) begin
        res = s - (lim + 1);
        break;
      end
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    m0 = SEED13;
    m1 = SEED13;
    m8 = 1;
  endtask

  task automatic drive(input int sel, input logic r, input logic [12:0] l, input logic e);
    if (sel == 0) begin req0 = r; lim0 = l; en0 = e; end
    else          begin req1 = r; lim1 = l; en1 = e; end
  endtask

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy0 : busy1;
  endfunction
  function automatic logic get_valid(input int sel);
    return (sel == 0) ? valid0 : valid1;
  endfunction
  function automatic logic [12:0] get_rnd(input int sel);
    return (sel == 0) ? rnd0 : rnd1;
  endfunction

  // One draw; lows counts low-enable edges that fall inside SHIFT phases.
  // Stray reqs and limit changes are injected while busy and must have no effect.
  task automatic draw(input int sel, input logic [12:0] lim, input bit gaps,
                      output logic [12:0] r, output int lat, output int lows, output bit bok);
    int sh;
    bit en;
    drive(sel, 1'b1, lim, 1'b1);
    tick;
    bok  = get_busy(sel);
    lat  = 0;
    lows = 0;
    sh   = 0;
    while (1) begin
      en = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      drive(sel, ($urandom_range(0, 7) == 0), 13'($urandom), en);
      tick;
      lat++;
      if (sh < STEPS) begin
        if (en) sh++;
        else lows++;
      end else begin
        sh = 0;
      end
      if (get_valid(sel)) begin
        if (get_busy(sel)) bok = 0;
        break;
      end
      if (!get_busy(sel)) bok = 0;
      if (lat >= 600) begin
        n_cmp++;
        n_bad++;
        $display("FAIL draw_timeout: no valid after %0d cycles, want one", lat);
        finish_now();
      end
    end
    drive(sel, 1'b0, lim, 1'b1);
    r = get_rnd(sel);
  endtask

  initial begin
    logic [12:0] r;
    int lat, lows, er, att;
    bit bok;

    en0 = 0; sl0 = 0; req0 = 0; seed0 = '0; lim0 = '0;
    en1 = 0; sl1 = 0; req1 = 0; seed1 = '0; lim1 = '0;
    en8 = 0; sl8 = 0; req8 = 0; seed8 = '0; lim8 = '0;

    vecs[0]  = '{2'd0, 13'h1FFF, 13'h1FF4, 8'd14};
    vecs[1]  = '{2'd0, 13'h0000, 13'h0000, 8'd14};
    vecs[2]  = '{2'd0, 13'h1FF4, 13'h1FF4, 8'd14};
    vecs[3]  = '{2'd0, 13'h0FF4, 13'h0FF4, 8'd14};
    vecs[4]  = '{2'd0, 13'h0007, 13'h0004, 8'd14};
    vecs[5]  = '{2'd0, 13'h0005, 13'h0004, 8'd14};
    vecs[6]  = '{2'd0, 13'h0004, 13'h0004, 8'd14};
    vecs[7]  = '{2'd0, 13'h0003, 13'h0000, 8'd14};
    vecs[8]  = '{2'd0, 13'h0008, 13'h0004, 8'd14};
    vecs[9]  = '{2'd1, 13'h0FF0, 13'h0003, 8'd14};
    vecs[10] = '{2'd1, 13'h0FF3, 13'h0000, 8'd14};
    vecs[11] = '{2'd1, 13'h1FF0, 13'h0003, 8'd14};
    vecs[12] = '{2'd1, 13'h0800, 13'h07F3, 8'd14};
    vecs[13] = '{2'd1, 13'h0002, 13'h0000, 8'd14};
    vecs[14] = '{2'd1, 13'h0010, 13'h0003, 8'd14};
    vecs[15] = '{2'd1, 13'h1FFF, 13'h1FF4, 8'd14};

    // Reset state
    reset = 1'b1;
    tick;
    check("reset_busy", busy0, 0);
    check("reset_valid", valid0, 0);
    check("reset_rnd", rnd0, 0);
    tick;
    reset = 1'b0;

    // Hand vectors, each from a fresh reset
    for (int i = 0; i < 16; i++) begin
      do_reset;
      draw(int'(vecs[i].sel), vecs[i].lim, 1'b0, r, lat, lows, bok);
      $display("vec %0d sel=%0d lim=%h rnd=%h lat=%0d", i, vecs[i].sel, vecs[i].lim, r, lat);
      check($sformatf("vec%0d_rnd", i), r, vecs[i].exp_rnd);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_busy", i), bok, 1);
    end

    // Enable gaps: delay equals low cycles in SHIFT, result unchanged
    for (int i = 0; i < 3; i++) begin
      do_reset;
      draw(0, 13'h1FFF, 1'b1, r, lat, lows, bok);
      $display("gap %0d rnd=%h lat=%0d lows=%0d", i, r, lat, lows);
      check("gap_rnd", r, 13'h1FF4);
      check("gap_lat", lat, 14 + lows);
    end

    // Zero seed falls back to SEED
    tick;
    sl0 = 1'b1; seed0 = 13'h0000;
    tick;
    sl0 = 1'b0;
    draw(0, 13'h1FFF, 1'b0, r, lat, lows, bok);
    $display("zero_seed rnd=%h lat=%0d", r, lat);
    check("zero_seed_rnd", r, 13'h1FF4);
    check("zero_seed_lat", lat, 14);

    // seed_load mid-SHIFT aborts the draw; a simultaneous req is ignored
    do_reset;
    draw(0, 13'h0FF4, 1'b0, r, lat, lows, bok);
    req0 = 1'b1; lim0 = 13'h1FFF;
    tick;
    req0 = 1'b0;
    repeat (4) tick;
    check("mid_shift_busy", busy0, 1);
    sl0 = 1'b1; seed0 = 13'h0ABC; req0 = 1'b1;
    tick;
    sl0 = 1'b0; req0 = 1'b0;
    check("sl_busy", busy0, 0);
    check("sl_valid", valid0, 0);
    check("sl_rnd", rnd0, 13'h0FF4);
    begin
      int vcount;
      vcount = 0;
      for (int k = 0; k < 20; k++) begin
        tick;
        if (valid0 || busy0) vcount++;
      end
      check("sl_quiet", vcount, 0);
    end
    m0 = 'h0ABC;
    model_draw(m0, 'h1FFF, 13, TAPS13, STEPS, 3, er, att);
    draw(0, 13'h1FFF, 1'b0, r, lat, lows, bok);
    $display("after_seed rnd=%h lat=%0d", r, lat);
    check("after_seed_rnd", r, er);

    // Asynchronous reset mid-draw
    do_reset;
    draw(0, 13'h1FFF, 1'b0, r, lat, lows, bok);
    req0 = 1'b1; lim0 = 13'h1FFF;
    tick;
    req0 = 1'b0;
    repeat (3) tick;
    #2;
    reset = 1'b1;
    #1;
    check("async_busy", busy0, 0);
    check("async_valid", valid0, 0);
    check("async_rnd", rnd0, 0);
    tick;
    reset = 1'b0;
    m0 = SEED13; m1 = SEED13; m8 = 1;
    draw(0, 13'h1FFF, 1'b0, r, lat, lows, bok);
    check("post_reset_rnd", r, 13'h1FF4);

    // Randomized draws against the model
    do_reset;
    for (int i = 0; i < 1000; i++) begin
      int sel;
      logic [12:0] lim;
      logic [12:0] sv;
      bit gaps;
      sel = ($urandom_range(0, 3) == 0) ? 1 : 0;
      case ($urandom_range(0, 3))
        0:       lim = 13'h1FFF;
        1:       lim = 13'($urandom_range(0, 15));
        default: lim = 13'($urandom) & 13'((1 << $urandom_range(1, 13)) - 1);
      endcase
      if ($urandom_range(0, 19) == 0) begin
        sv = ($urandom_range(0, 3) == 0) ? 13'h0000 : 13'($urandom);
        if (sel == 0) begin sl0 = 1'b1; seed0 = sv; req0 = 1'b1; end
        else          begin sl1 = 1'b1; seed1 = sv; req1 = 1'b1; end
        tick;
        sl0 = 1'b0; sl1 = 1'b0; req0 = 1'b0; req1 = 1'b0;
        check("rand_sl_busy", get_busy(sel), 0);
        if (sel == 0) m0 = (sv == 0) ? int'(SEED13) : int'(sv);
        else          m1 = (sv == 0) ? int'(SEED13) : int'(sv);
      end
      gaps = 1'($urandom_range(0, 1));
      if (sel == 0) model_draw(m0, int'(lim), 13, TAPS13, STEPS, 3, er, att);
      else          model_draw(m1, int'(lim), 13, TAPS13, STEPS, 0, er, att);
      draw(sel, lim, gaps, r, lat, lows, bok);
      $display("rand %0d sel=%0d lim=%h rnd=%h exp=%h lat=%0d", i, sel, lim, r, er[12:0], lat);
      check("rand_rnd", r, er);
      check("rand_lat", lat, att * (STEPS + 1) + lows);
      check("rand_range", (r <= lim), 1);
      check("rand_busy", bok, 1);
      if ($urandom_range(0, 3) == 0) begin
        tick;
        check("rand_valid_pulse", get_valid(sel), 0);
        check("rand_idle", get_busy(sel), 0);
      end
    end

    // 8-bit maximal-length period: 255 draws cover every nonzero value once
    do_reset;
    begin
      bit seen [256];
      int distinct, bad_model, bad_lat;
      distinct = 0; bad_model = 0; bad_lat = 0;
      for (int k = 0; k < 256; k++) seen[k] = 1'b0;
      for (int i = 0; i < 255; i++) begin
        int l8;
        model_draw(m8, 255, 8, 'hB8, 1, 3, er, att);
        req8 = 1'b1; lim8 = 8'hFF; en8 = 1'b1;
        tick;
        req8 = 1'b0;
        l8 = 0;
        while (l8 < 20) begin
          tick;
          l8++;
          if (valid8) break;
        end
        if (!valid8) begin
          n_cmp++;
          n_bad++;
          $display("FAIL p8_timeout: no valid after %0d cycles, want one", l8);
          finish_now();
        end
        $display("p8 %0d rnd=%h exp=%h lat=%0d", i, rnd8, er[7:0], l8);
        if (int'(rnd8) != er) bad_model++;
        if (l8 != 2) bad_lat++;
        if (!seen[rnd8]) begin
          seen[rnd8] = 1'b1;
          distinct++;
        end
      end
      check("p8_distinct", distinct, 255);
      check("p8_zero_seen", seen[0], 0);
      check("p8_model", bad_model, 0);
      check("p8_lat", bad_lat, 0);
    end

    finish_now();
  end

endmodule
